// File: rtl/cache_msg_bus.sv
// Round-robin message bus for cache controllers: grants one sender at a time and
// delivers its message to the addressed cache, or to every other cache on broadcast.
module cache_msg_bus #(
    parameter int cache_num  = 2,
    parameter int addr_width = 32,
    localparam int ID_W  = $clog2(cache_num),
    localparam int MSG_W = 4 + 2*ID_W + addr_width
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [cache_num-1:0]       msg_req,
    input  logic [cache_num*MSG_W-1:0] msg,
    output logic [cache_num-1:0]       msg_gnt,
    output logic [MSG_W-1:0]           msg_in,
    output logic [cache_num-1:0]       msg_in_valid,
    output logic                       msg_err,
    output logic [31:0]                msg_count
);

    typedef enum logic [1:0] {IDLE, GNT, BCAST} state_t;

    state_t               state, next_state;
    logic [ID_W-1:0]      idx, winner, cand, src, dst;
    logic                 found, dst_hit;
    logic [cache_num-1:0] req_mask;
    logic [MSG_W-1:0]     held, cur_msg;
    logic [31:0]          count;

    assign src       = held[MSG_W-5 -: ID_W];
    assign dst       = held[MSG_W-5-ID_W -: ID_W];
    assign msg_in    = held;
    assign msg_count = count;

    // idx doubles as the last winner, so the search naturally starts one past it.
    // The sender being delivered is masked so it cannot be regranted back-to-back.
    always_comb begin
        req_mask = msg_req;
        if (state == BCAST) req_mask[idx] = 1'b0;
        found  = 1'b0;
        winner = idx;
        cand   = idx;
        for (int k = 1; k <= cache_num; k++) begin
            cand = ID_W'((int'(idx) + k) % cache_num);
            if (!found && req_mask[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        cur_msg = '0;
        for (int i = 0; i < cache_num; i++) begin
            if (idx == ID_W'(i)) cur_msg = msg[i*MSG_W +: MSG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = found ? GNT : IDLE;
            GNT:     next_state = BCAST;
            BCAST:   next_state = found ? GNT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= ID_W'(cache_num - 1);
            held  <= '0;
            count <= '0;
        end else begin
            if ((state == IDLE || state == BCAST) && found) idx <= winner;
            if (state == GNT) begin
                held  <= cur_msg;
                count <= count + 32'd1;
            end
        end
    end

    // A unicast to itself or to a nonexistent cache is dropped and flagged;
    // a wrong src field is flagged but still delivered.
    always_comb begin
        msg_gnt      = '0;
        msg_in_valid = '0;
        msg_err      = 1'b0;
        dst_hit      = 1'b0;
        case (state)
            GNT: msg_gnt[idx] = 1'b1;
            BCAST: begin
                if (held[MSG_W-1]) begin
                    msg_in_valid      = '1;
                    msg_in_valid[idx] = 1'b0;
                end else begin
                    for (int i = 0; i < cache_num; i++) begin
                        if (dst == ID_W'(i) && idx != ID_W'(i)) begin
                            msg_in_valid[i] = 1'b1;
                            dst_hit         = 1'b1;
                        end
                    end
                    if (!dst_hit) msg_err = 1'b1;
                end
                if (src != idx) msg_err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_msg_bus.sv
// Self-checking bench for cache_msg_bus with four caches: a transaction-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cache_msg_bus;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int ID_W  = $clog2(N);
    localparam int MSG_W = 4 + 2*ID_W + AW;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       msg_req;
    logic [N*MSG_W-1:0] msg;
    logic [N-1:0]       msg_gnt;
    logic [MSG_W-1:0]   msg_in;
    logic [N-1:0]       msg_in_valid;
    logic               msg_err;
    logic [31:0]        msg_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cache_msg_bus #(.cache_num(N), .addr_width(AW)) dut (
        .clk(clk), .rst(rst), .msg_req(msg_req), .msg(msg), .msg_gnt(msg_gnt),
        .msg_in(msg_in), .msg_in_valid(msg_in_valid), .msg_err(msg_err),
        .msg_count(msg_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [MSG_W-1:0] mkMsg(input int op, input int src, input int dst,
                                               input int addr);
        return {op[3:0], src[ID_W-1:0], dst[ID_W-1:0], addr[AW-1:0]};
    endfunction

    // Model: each cycle is either quiet, a grant to one cache, or the delivery of
    // the message captured at the end of that grant.
    int               m_kind = 0;
    int               m_idx  = 0;
    int               m_last = N - 1;
    logic [MSG_W-1:0] m_held = '0;
    logic [31:0]      m_count = '0;
    logic [N-1:0]     e_gnt, e_valid;
    logic             e_err;
    bit               model_on = 0;

    task automatic modelStep();
        int win, c, op, src, dst;
        if (rst) begin
            m_kind = 0; m_last = N - 1; m_held = '0; m_count = '0; model_on = 1;
        end else if (m_kind == 1) begin
            m_held  = msg[m_idx*MSG_W +: MSG_W];
            m_count = m_count + 1;
            m_kind  = 2;
        end else begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (win < 0 && msg_req[c] && !(m_kind == 2 && c == m_idx)) win = c;
            end
            if (win >= 0) begin
                m_kind = 1; m_idx = win; m_last = win;
            end else begin
                m_kind = 0;
            end
        end
        e_gnt = '0; e_valid = '0; e_err = 1'b0;
        if (m_kind == 1) e_gnt = N'(1 << m_idx);
        if (m_kind == 2) begin
            op  = int'(m_held >> (MSG_W - 4));
            src = int'(m_held >> (MSG_W - 4 - ID_W)) % (1 << ID_W);
            dst = int'(m_held >> AW) % (1 << ID_W);
            if (op >= 8) e_valid = N'(((1 << N) - 1) & ~(1 << m_idx));
            else if (dst != m_idx && dst < N) e_valid = N'(1 << dst);
            else e_err = 1'b1;
            if (src != m_idx) e_err = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            checkOutput("model msg_gnt", 64'(msg_gnt), 64'(e_gnt));
            checkOutput("model msg_in_valid", 64'(msg_in_valid), 64'(e_valid));
            checkOutput("model msg_err", 64'(msg_err), 64'(e_err));
            checkOutput("model msg_in", 64'(msg_in), 64'(m_held));
            checkOutput("model msg_count", 64'(msg_count), 64'(m_count));
        end
    end

    int gnt_order[$];
    int gnt_cycle[$];

    // Waits at negedges for a grant to cache i; a timeout counts as a failure.
    task automatic waitGnt(input int i, output int waited, output bit ok);
        ok = 0;
        for (waited = 1; waited <= 40; waited++) begin
            @(negedge clk);
            if (msg_gnt[i]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("[TB] FAIL grant timeout for cache %0d: got no grant, expected one within 40 cycles", i);
            msg_req[i] = 1'b0;
        end
    endtask

    task automatic sendOne(input int i, input logic [MSG_W-1:0] m, input logic [N-1:0] x_valid,
                           input logic x_err);
        int  waited;
        bit  ok;
        msg[i*MSG_W +: MSG_W] = m;
        msg_req[i] = 1'b1;
        waitGnt(i, waited, ok);
        if (ok) begin
            checkOutput("grant latency", 64'(waited), 64'd1);
            checkOutput("grant one-hot", 64'(msg_gnt), 64'(1 << i));
            @(negedge clk);
            msg_req[i] = 1'b0;
            checkOutput("delivery valid", 64'(msg_in_valid), 64'(x_valid));
            checkOutput("delivery err", 64'(msg_err), 64'(x_err));
            checkOutput("delivery msg_in", 64'(msg_in), 64'(m));
        end
        @(negedge clk);
    endtask

    task automatic streamer(input int i, input int n, input int base);
        int waited;
        bit ok;
        for (int k = 0; k < n; k++) begin
            msg[i*MSG_W +: MSG_W] = mkMsg(0, i, (i + 1) % N, base + k);
            msg_req[i] = 1'b1;
            waitGnt(i, waited, ok);
            if (!ok) return;
            gnt_order.push_back(i);
            gnt_cycle.push_back(cyc);
            @(negedge clk);
            if (k == n - 1) msg_req[i] = 1'b0;
        end
    endtask

    task automatic applyStimulus();
        int exp_pair[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int exp_rot[8]  = '{2, 3, 0, 1, 2, 3, 0, 1};
        int waited;
        bit ok;

        rst = 1'b1; msg_req = '0; msg = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset msg_gnt", 64'(msg_gnt), 64'd0);
        checkOutput("reset msg_in_valid", 64'(msg_in_valid), 64'd0);
        checkOutput("reset msg_in", 64'(msg_in), 64'd0);
        checkOutput("reset msg_count", 64'(msg_count), 64'd0);
        rst = 1'b0;

        sendOne(0, mkMsg(0, 0, 1, 32'h1000), 4'b0010, 1'b0);
        checkOutput("count after first", 64'(msg_count), 64'd1);
        sendOne(2, mkMsg(8, 2, 0, 32'h2000), 4'b1011, 1'b0);
        sendOne(1, mkMsg(0, 1, 1, 32'h3000), 4'b0000, 1'b1);
        checkOutput("count after self-send", 64'(msg_count), 64'd3);
        sendOne(0, mkMsg(0, 1, 3, 32'h4000), 4'b1000, 1'b1);

        gnt_order.delete(); gnt_cycle.delete();
        fork
            streamer(0, 4, 32'h100);
            streamer(1, 4, 32'h200);
        join
        checkOutput("pair grant total", 64'(gnt_order.size()), 64'd8);
        for (int k = 0; k < gnt_order.size() && k < 8; k++) begin
            checkOutput("pair grant order", 64'(gnt_order[k]), 64'(exp_pair[k]));
            if (k > 0) checkOutput("pair grant spacing", 64'(gnt_cycle[k] - gnt_cycle[k-1]), 64'd2);
        end
        @(negedge clk);
        checkOutput("count after pair", 64'(msg_count), 64'd12);

        msg[1*MSG_W +: MSG_W] = mkMsg(0, 1, 2, 32'h5000);
        msg_req[1] = 1'b1;
        waitGnt(1, waited, ok);
        if (ok) begin
            rst = 1'b1;
            @(negedge clk);
            checkOutput("abort no valid", 64'(msg_in_valid), 64'd0);
            checkOutput("abort count", 64'(msg_count), 64'd0);
            rst = 1'b0;
            @(negedge clk);
            checkOutput("regrant after reset", 64'(msg_gnt), 64'b0010);
            @(negedge clk);
            msg_req[1] = 1'b0;
            checkOutput("delivery after reset", 64'(msg_in_valid), 64'b0100);
            checkOutput("count after reset", 64'(msg_count), 64'd1);
        end
        @(negedge clk);

        gnt_order.delete(); gnt_cycle.delete();
        fork
            streamer(0, 2, 32'h600);
            streamer(1, 2, 32'h700);
            streamer(2, 2, 32'h800);
            streamer(3, 2, 32'h900);
        join
        checkOutput("rotation total", 64'(gnt_order.size()), 64'd8);
        for (int k = 0; k < gnt_order.size() && k < 8; k++)
            checkOutput("rotation order", 64'(gnt_order[k]), 64'(exp_rot[k]));
        @(negedge clk);
        checkOutput("count after rotation", 64'(msg_count), 64'd9);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_msg_bus.md
CACHE_MSG_BUS -- requirements
Module: cache_msg_bus

Interface
REQ-001 Parameter cache_num, default 2, number of attached cache controllers (legal range 2..16).
REQ-002 Parameter addr_width, default 32, coherence address width.
REQ-003 Derived constants: ID_W = $clog2(cache_num); MSG_W = 4 + 2*ID_W + addr_width.
REQ-004 Message layout SHALL be {op[3:0], src[ID_W-1:0], dst[ID_W-1:0], addr[addr_width-1:0]}, MSB first; op[3]=1 means broadcast.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-007 msg_req  in  cache_num  per-cache request to send a message; bit i belongs to cache i.
REQ-008 msg  in  cache_num*MSG_W  per-cache message; slice i = msg[i*MSG_W +: MSG_W].
REQ-009 msg_gnt  out  cache_num  one-hot, one-cycle grant; the granted cache's msg is captured in this cycle.
REQ-010 msg_in  out  MSG_W  delivered message, shared by all caches.
REQ-011 msg_in_valid  out  cache_num  per-cache delivery strobe for msg_in.
REQ-012 msg_err  out  1  one-cycle pulse: the delivered message was malformed.
REQ-013 msg_count  out  32  count of messages accepted (granted), wraps at 2^32.

Function
REQ-014 FSM SHALL have states IDLE, GNT, BCAST.
REQ-015 IDLE: if any msg_req bit is set, register the round-robin winner idx and go to GNT; otherwise stay in IDLE.
REQ-016 Round-robin: the search starts at (last_winner+1) mod cache_num and wraps; last_winner resets to cache_num-1, so cache 0 has first priority.
REQ-017 GNT: msg_gnt[idx]=1 for exactly this cycle; msg slice idx is captured into a holding register; msg_count increments by 1; go to BCAST.
REQ-018 BCAST: msg_in drives the held message; msg_in_valid and msg_err are driven per REQ-019..REQ-021 for exactly this cycle.
REQ-019 Broadcast (op[3]=1): msg_in_valid = all ones except bit idx.
REQ-020 Unicast (op[3]=0): msg_in_valid = one-hot bit dst if dst != idx and dst < cache_num; otherwise msg_in_valid = 0 and msg_err = 1 (message dropped).
REQ-021 If the src field differs from idx, msg_err = 1; delivery still proceeds per REQ-019/REQ-020 with msg_in unmodified.
REQ-022 BCAST exit: ignore msg_req[idx]; if any other request is set, register the next round-robin winner and go to GNT; otherwise go to IDLE.
REQ-023 Latency: request seen at cycle t in IDLE gives msg_gnt at t+1 and msg_in_valid at t+2; back-to-back grants are spaced 2 cycles apart.
REQ-024 Requesters hold msg_req and msg stable until msg_gnt and drop msg_req the cycle after; the bus SHALL NOT regrant the same cache in the BCAST cycle.
REQ-025 Simultaneous requests from all caches SHALL be served in strict rotation, with no cache granted twice before every other pending cache has been granted once.
REQ-026 msg_gnt SHALL be zero outside GNT; msg_in_valid and msg_err SHALL be zero outside BCAST; msg_in holds its last value when invalid.
REQ-027 Changes to msg_req in GNT or BCAST SHALL NOT alter the current grant or delivery.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, msg_gnt=0, msg_in_valid=0, msg_err=0, msg_in=0, msg_count=0, last_winner=cache_num-1.
REQ-029 Reset asserted in GNT or BCAST SHALL abort the transaction; no msg_in_valid pulse follows; the interrupted requester re-arbitrates after reset.
REQ-030 The first possible grant SHALL occur 2 cycles after rst deasserts, given a request present at the first non-reset edge.

Verification
REQ-031 cache_num=2: cache0 requests a unicast with src=0, dst=1, addr=0x1000 at t -> msg_gnt=2'b01 at t+1; msg_in_valid=2'b10 with msg_in addr 0x1000 at t+2; msg_count=1.
REQ-032 Both caches request continuously, 4 messages each -> grants alternate 0,1,0,1,... with a grant every 2 cycles; msg_count=8.
REQ-033 cache_num=4: broadcast (op=4'b1000) from cache2 -> msg_in_valid=4'b1011.
REQ-034 Unicast from cache1 with dst=1 -> msg_in_valid=0 and msg_err=1 for one cycle; msg_count still increments.
REQ-035 cache0 sends with src=1 -> msg_err=1 and delivery to dst still occurs.
REQ-036 rst asserted during GNT -> no msg_in_valid; after release, the pending request is granted at release+2 and msg_count restarts from 0.
